// File: rtl/pkt_dispatch.sv
// Packet dispatcher: queues {type, dest_match} headers and fans each one out to the
// processing blocks selected by ROUTE_MAP, then holds until they all report done or time out.
module pkt_dispatch #(
  parameter int                             TYPE_W    = 3,
  parameter int                             ID_W      = 16,
  parameter int                             NCH       = 4,
  parameter int                             DEPTH     = 4,
  parameter logic [(2**TYPE_W)*NCH-1:0]     ROUTE_MAP = 32'h099A1C6A,
  parameter logic [ID_W-1:0]                BCAST_ID  = {ID_W{1'b1}},
  parameter int                             TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      newpkt,
  input  logic [TYPE_W-1:0]         fPktType,
  input  logic [ID_W-1:0]           destinationID,
  input  logic [ID_W-1:0]           myNodeID,
  output logic                      pkt_ready,
  output logic [NCH-1:0]            en,
  output logic                      iAmDestination,
  output logic [TYPE_W-1:0]         pkt_type_out,
  input  logic [NCH-1:0]            ch_done,
  output logic                      busy,
  output logic                      timeout_pulse,
  output logic [7:0]                drop_cnt,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  logic [TYPE_W-1:0] type_mem [DEPTH];
  logic              dm_mem   [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  state_t            state, state_d;
  logic [TYPE_W-1:0] type_q;
  logic              dm_q;
  logic [NCH-1:0]    mask_q, pending, pending_d, remaining;
  logic [TW-1:0]     wait_cnt;

  logic              push, pop, dest_match;
  logic [TYPE_W-1:0] head_type;
  logic [NCH-1:0]    head_mask;

  // Full is judged from the registered count only, so a same-cycle pop cannot rescue a push.
  assign pkt_ready  = (count != CW'(DEPTH));
  assign push       = newpkt & pkt_ready;
  assign dest_match = (destinationID == myNodeID) || (destinationID == BCAST_ID);
  assign head_type  = type_mem[rd_ptr];
  assign head_mask  = ROUTE_MAP[int'(head_type)*NCH +: NCH];
  assign remaining  = pending & ~ch_done;

  assign busy           = (state != IDLE);
  assign iAmDestination = busy & dm_q;
  assign pkt_type_out   = busy ? type_q : '0;
  assign fifo_count     = count;

  always_comb begin
    state_d       = state;
    pending_d     = pending;
    pop           = 1'b0;
    timeout_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (head_mask != '0) state_d = ISSUE;
        end
      end
      ISSUE: begin
        pending_d = mask_q;
        state_d   = WAIT;
      end
      WAIT: begin
        pending_d = remaining;
        if (remaining == '0) begin
          state_d = IDLE;
        end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          timeout_pulse = 1'b1;
          pending_d     = '0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      type_q   <= '0;
      dm_q     <= 1'b0;
      mask_q   <= '0;
      pending  <= '0;
      wait_cnt <= '0;
      en       <= '0;
    end else begin
      state   <= state_d;
      pending <= pending_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (newpkt && !pkt_ready && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      // en is registered so the burst lands exactly in the ISSUE cycle.
      en <= (pop && head_mask != '0) ? head_mask : '0;
      if (pop) begin
        type_q <= head_type;
        dm_q   <= dm_mem[rd_ptr];
        mask_q <= head_mask;
      end
      wait_cnt <= (state == WAIT && state_d == WAIT) ? wait_cnt + TW'(1) : '0;
    end
  end

  // Header storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      type_mem[wr_ptr] <= fPktType;
      dm_mem[wr_ptr]   <= dest_match;
    end
  end

endmodule

// File: doc/pkt_dispatch.md
# pkt_dispatch

Parametrised packet dispatcher sitting between the packet receiver and the per-node processing blocks (QTableUpdate, myNodeInfo, knownCH, reward). It queues incoming packet headers in a small FIFO and maps each packet type to a set of channel enables through a configurable route map. It issues a one-cycle enable burst, then holds until every enabled block reports done, with a timeout. Successor to the fixed-mapping filter: it adds queuing, back-pressure, broadcast addressing, completion tracking and drop/timeout accounting.

## Interface
- TYPE_W, 3, packet-type field width; 2^TYPE_W types.
- ID_W, 16, node ID width.
- NCH, 4, output channels; default order 0=QTU, 1=MNI, 2=KCH, 3=reward.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ROUTE_MAP, 32'h099A1C6A, (2^TYPE_W)*NCH bits; bits [t*NCH +: NCH] give the channel mask for type t. The default reproduces the legacy mapping: type 0→MNI+reward, 1→MNI+KCH, 2→KCH+reward, 3→QTU, 4→MNI+reward, 5/6→QTU+reward, 7→none.
- BCAST_ID, {ID_W{1'b1}}, destination ID treated as matching every node.
- TIMEOUT, 255, maximum WAIT cycles before abort; ≥1.
- clk  in  1  clock; all state on rising edge.
- nrst  in  1  asynchronous active-low reset.
- newpkt  in  1  push strobe; one header per high cycle.
- fPktType  in  TYPE_W  packet type of the pushed header.
- destinationID  in  ID_W  destination of the pushed header.
- myNodeID  in  ID_W  this node's ID, from myNodeInfo.
- pkt_ready  out  1  FIFO not full.
- en  out  NCH  channel enables; one-cycle pulse.
- iAmDestination  out  1  valid in ISSUE and WAIT.
- pkt_type_out  out  TYPE_W  type of the packet in service; valid in ISSUE and WAIT.
- ch_done  in  NCH  per-channel completion pulses.
- busy  out  1  high in ISSUE or WAIT.
- timeout_pulse  out  1  one-cycle pulse on abort.
- drop_cnt  out  8  saturating count of headers dropped because the FIFO was full.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Enqueue: if newpkt && pkt_ready, write {fPktType, dest_match} to the tail. dest_match = (destinationID==myNodeID) || (destinationID==BCAST_ID), computed at push time. If newpkt && !pkt_ready, discard the header and increment drop_cnt, saturating at 255. pkt_ready depends only on the registered full flag, so a push while full is dropped even if a pop occurs in the same cycle.
- The FSM has three states: IDLE, ISSUE, WAIT.
- IDLE: if the FIFO is non-empty, pop the head and latch type, dest_match and mask = ROUTE_MAP slice.
  - mask≠0: go to ISSUE.
  - mask==0: stay in IDLE, packet consumed silently, one pop per cycle.
- ISSUE: for one cycle, en=mask and pending=mask. Go to WAIT. ch_done is ignored in this cycle.
- WAIT: each cycle, pending &= ~ch_done, and wait_cnt increments from 0.
  - If the next pending is 0, go to IDLE.
  - Else if wait_cnt==TIMEOUT-1, pulse timeout_pulse, clear pending, go to IDLE.
  - ch_done on non-pending channels is ignored.
- Simultaneous push and pop: both happen; fifo_count is unchanged. Pointers wrap modulo DEPTH.
- Reset, asynchronous and possible at any time: state=IDLE, FIFO emptied, and all of these go to 0: en, pending, wait_cnt, busy, iAmDestination, pkt_type_out, timeout_pulse, drop_cnt, fifo_count. pkt_ready=1.

## Timing
- Push at cycle N into an empty FIFO with the FSM in IDLE: en pulses in cycle N+2 (registered output).
- iAmDestination and pkt_type_out are held from ISSUE through the last WAIT cycle, and are 0 in IDLE.
- A done seen in WAIT cycle k makes IDLE cycle k+1. The next packet can be ISSUEd at k+2, so the minimum service period is 3 cycles per routed packet.
- Unrouted (mask 0) packets cost one IDLE cycle each.
- Timeout: with no done, timeout_pulse is high in the TIMEOUT-th WAIT cycle, and IDLE follows.

## Test plan
- Reset, then push type 3'b101 with destinationID=myNodeID=16'h0007 at cycle 0. Required: en=4'b1001 in cycle 2 only; iAmDestination=1 and busy=1 from cycle 2. Then ch_done=4'b0001 at cycle 4 and 4'b1000 at cycle 5: busy drops in cycle 6.
- Push type 3'b111: no en pulse, fifo_count returns to 0, busy stays 0. Then push type 3'b001 with destinationID=16'hFFFF and myNodeID=16'h0003: en=4'b0110 and iAmDestination=1.
- Push 6 back-to-back headers while the FSM is stalled in WAIT with DEPTH=4. Required: pkt_ready=0 after the 4th, drop_cnt=2, and the 4 queued packets are issued in order after done.
- Type 3'b000 issued with no ch_done and TIMEOUT=255. Required: timeout_pulse in the 255th WAIT cycle, FSM back in IDLE, and the next queued packet issued.
- Assert nrst low mid-WAIT with 3 entries queued. Required: all outputs 0 immediately, pkt_ready=1, fifo_count=0; after release, no en until a new push.
- Push 300 headers while full. Required: drop_cnt saturates at 255.
